// File: rtl/uart_dbg_pkg.sv
// Shared types and constants for the debug UART path: arbiter state,
// byte width, requester indices and a small one-hot decode helper.
package uart_dbg_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    localparam int UART_BYTE_W = 8;

    localparam int REQ_CORE = 0;
    localparam int REQ_DBG  = 1;

    // Index of the set bit in a one-hot vector of up to 8 requesters.
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) oh2idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART TX.
// master = requester/UART side, slave = arbiter.
interface uart_tx_arbiter_if
    import uart_dbg_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]             req_valid_i;
    logic [UART_BYTE_W*N_REQ-1:0] req_data_i;
    logic [N_REQ-1:0]             req_last_i;
    logic [N_REQ-1:0]             req_ready_o;
    logic                         tx_valid_o;
    logic [UART_BYTE_W-1:0]       tx_data_o;
    logic                         tx_ready_i;
    logic [N_REQ-1:0]             grant_o;
    logic                         busy_o;
    logic                         timeout_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_ready_i,
        input  req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
        output req_ready_o, tx_valid_o, tx_data_o, grant_o, busy_o, timeout_o
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr, wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    int idx;

    // Walk from the farthest offset down so the nearest hit overwrites.
    always_comb begin
        gnt = '0;
        idx = 0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte channel,
// with an idle timeout that revokes a grant stalled mid-packet.
module uart_tx_arbiter
    import uart_dbg_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    uart_tx_arbiter_if.slave  bus
);

    localparam int PW   = $clog2(N_REQ);
    localparam int CW   = (CNT_W > 0) ? CNT_W : 1;
    localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    arb_state_t             state, state_n;
    logic [N_REQ-1:0]       grant, grant_n, pick;
    logic                   any;
    logic [PW-1:0]          rr_ptr, rr_ptr_n, ptr_after;
    logic [2:0]             g_idx;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   timeout, timeout_n;
    logic                   vld_g, last_g, fire;
    logic [UART_BYTE_W-1:0] data_g;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req (bus.req_valid_i),
        .ptr (rr_ptr),
        .gnt (pick),
        .any (any)
    );

    // Grant is one-hot or zero, so an AND-OR mux also yields 0 when idle.
    always_comb begin
        data_g = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) data_g = data_g | bus.req_data_i[k*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    assign vld_g     = |(bus.req_valid_i & grant);
    assign last_g    = |(bus.req_last_i & grant);
    assign fire      = vld_g & bus.tx_ready_i;
    assign g_idx     = oh2idx(8'(grant));
    assign ptr_after = PW'((int'(g_idx) + 1) % N_REQ);

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        rr_ptr_n  = rr_ptr;
        cnt_n     = cnt;
        timeout_n = 1'b0;
        case (state)
            ARB_IDLE: begin
                cnt_n = '0;
                if (any) begin
                    grant_n = pick;
                    state_n = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (fire && last_g) begin
                    state_n  = ARB_IDLE;
                    grant_n  = '0;
                    rr_ptr_n = ptr_after;
                    cnt_n    = '0;
                end else if (vld_g) begin
                    // Valid held under UART backpressure is not a stall.
                    cnt_n = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt == CW'(TLIM)) begin
                        state_n   = ARB_IDLE;
                        grant_n   = '0;
                        rr_ptr_n  = ptr_after;
                        cnt_n     = '0;
                        timeout_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ARB_IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            rr_ptr  <= rr_ptr_n;
            cnt     <= cnt_n;
            timeout <= timeout_n;
        end
    end

    assign bus.req_ready_o = grant & {N_REQ{bus.tx_ready_i}};
    assign bus.tx_valid_o  = vld_g;
    assign bus.tx_data_o   = data_g;
    assign bus.grant_o     = grant;
    assign bus.busy_o      = (state == ARB_LOCKED);
    assign bus.timeout_o   = timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte channel between N_REQ requesters, e.g. core console output (req 0) and debugger responses (req 1).
- Sits between the requester byte streams and the UART TX serializer, inside the FPGA top level.
- Grants are round-robin and packet-locked: a grant is held until the requester's "last" byte is accepted.
- An idle-timeout releases a grant held by a requester that has stalled mid-packet.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 65535, cycles the granted requester may hold req_valid low mid-packet before the grant is revoked; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  N_REQ  per-requester byte valid.
- req_data_i  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  in  N_REQ  marks the final byte of a packet; sampled with valid.
- req_ready_o  out  N_REQ  per-requester accept.
- tx_valid_o  out  1  byte valid toward the UART TX.
- tx_data_o  out  8  byte toward the UART TX.
- tx_ready_i  in  1  the UART TX can accept a byte (not busy).
- grant_o  out  N_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high whenever a grant is held.
- timeout_o  out  1  one-cycle pulse when a grant is revoked by the timeout.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant_o=0, rr_ptr=0, timeout counter=0.
  - busy_o=0, timeout_o=0, tx_valid_o=0, req_ready_o=0, tx_data_o=0.
- Handshake: a transfer occurs on any cycle with tx_valid_o && tx_ready_i.
  - The same cycle, req_ready_o[g] is high for the granted index g only.
- IDLE state:
  - If any req_valid_i is high, select the first requester at or after rr_ptr, searching upward with wrap modulo N_REQ.
  - Register it into grant_o and go to LOCKED.
  - No transfer happens in IDLE; grant-to-first-byte latency is 1 cycle after req_valid_i rises.
- LOCKED state, datapath (combinational from the grant register):
  - tx_valid_o = req_valid_i[g].
  - tx_data_o = req_data_i[g].
  - req_ready_o[g] = tx_ready_i.
  - All other req_ready_o bits stay 0.
  - tx_data_o = 0 when idle.
- LOCKED state, end of packet:
  - On a transfer with req_last_i[g]=1: next state IDLE, grant_o cleared, rr_ptr = (g+1) mod N_REQ.
  - A new arbitration takes 1 IDLE cycle, so packets are separated by at least one idle cycle.
- LOCKED state, timeout counter:
  - Increments each cycle with req_valid_i[g]=0.
  - Clears on any cycle with req_valid_i[g]=1.
  - Does not count while valid is high and tx_ready_i is low; the UART backpressure is legitimate.
- LOCKED state, timeout expiry:
  - When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): pulse timeout_o for 1 cycle, go to IDLE, clear grant_o, rr_ptr=(g+1) mod N_REQ, counter=0.
- Single-byte packet (last on the first byte): LOCKED lasts exactly 1 cycle when tx_ready_i=1.
- Simultaneous requests: the round-robin pointer decides; after a release the just-served requester has lowest priority.
- A requester dropping valid mid-packet keeps the grant until the timeout; other requesters are blocked during this time.
- req_last_i without req_valid_i is ignored.
- busy_o = (state==LOCKED).
- Reset asserted mid-packet: everything returns to reset values immediately; the partial packet is abandoned with no flush.

Decomposition:
- Shared package uart_dbg_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
  - UART_BYTE_W=8.
  - Requester index constants REQ_CORE=0, REQ_DBG=1.
- Natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot choice and an any-request flag.
  - Reusable by other shared resources in the debugger.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with tx_ready_i=1.
  - Required: grant_o=01 one cycle after valid; tx_data_o sequence 41,42,43; grant_o returns to 00; rr_ptr=1.
- Contention: req0 and req1 both valid from reset, each sending a 2-byte packet.
  - Required: req0 served first, then 1 idle cycle, then req1.
  - Repeat with both valid again: req0 after req1, confirming round-robin alternation.
- Backpressure: tx_ready_i low for 5 cycles mid-packet while req1 holds valid.
  - Required: tx_data_o stable, req_ready_o=00, no timeout_o, grant_o stays 10.
- Timeout (TIMEOUT_CYCLES=8): req0 sends 1 non-last byte, then drops valid.
  - Required: timeout_o pulses exactly 8 cycles after valid falls; grant_o goes to 00; a pending req1 is granted on the next cycle.
- Lock hold: req0 mid-packet while req1 asserts valid.
  - Required: req_ready_o[1] stays 0 until req0's last byte is accepted.
- Reset mid-packet: assert rst_i while LOCKED.
  - Required: all outputs go to 0 asynchronously.
  - After release, a req1 request is granted first (rr_ptr=0 with only req1 pending).
